// File: rtl/ecore_pkg.sv
// Shared definitions for the ecore core and its load/store unit.
package ecore_pkg;

    // Load/store unit sequencing states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_t;

    // Access size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // GPIO register offsets inside the IO region
    localparam logic [3:0] IO_GPIO_OUT = 4'h0;
    localparam logic [3:0] IO_GPIO_DIR = 4'h4;
    localparam logic [3:0] IO_GPIO_IN  = 4'h8;

    // Major opcodes shared with the core decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation selects shared with the core execute stage
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    // Pick the addressed byte/half lane out of a word and extend it to 32 bits
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Merge the low byte/half of store data into the addressed lane of an old word
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    res = {old[31:8], wdata[7:0]};
                    2'd1:    res = {old[31:16], wdata[7:0], old[7:0]};
                    2'd2:    res = {old[31:24], wdata[7:0], old[15:0]};
                    default: res = {wdata[7:0], old[23:0]};
                endcase
            end
            SZ_HALF: res = lane[1] ? {wdata[15:0], old[15:0]} : {old[31:16], wdata[15:0]};
            default: res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ecore_gpio_bank.sv
// 32-bit GPIO bank: output/direction registers, 2-flop input synchronizer,
// per-pad tristate drive and a single word read/write port.
module ecore_gpio_bank
    import ecore_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_offset,
    input  logic [31:0] wr_data,
    input  logic [3:0]  rd_offset,
    output logic [31:0] rd_data,
    inout  wire  [31:0] pads
);

    logic [31:0] out_r;
    logic [31:0] dir_r;
    logic [31:0] sync1_r;
    logic [31:0] sync2_r;

    // Register writes and pad synchronisation
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r   <= 32'h0000_0000;
            dir_r   <= 32'h0000_0000;
            sync1_r <= 32'h0000_0000;
            sync2_r <= 32'h0000_0000;
        end else begin
            sync1_r <= pads;
            sync2_r <= sync1_r;
            if (wr_en) begin
                case (wr_offset)
                    IO_GPIO_OUT: out_r <= wr_data;
                    IO_GPIO_DIR: dir_r <= wr_data;
                    default:     out_r <= out_r;
                endcase
            end else begin
                out_r <= out_r;
            end
        end
    end

    // Read mux; unmapped offsets read as zero
    always_comb begin
        rd_data = 32'h0000_0000;
        case (rd_offset)
            IO_GPIO_OUT: rd_data = out_r;
            IO_GPIO_DIR: rd_data = dir_r;
            IO_GPIO_IN:  rd_data = sync2_r;
            default:     rd_data = 32'h0000_0000;
        endcase
    end

    // Each pad is driven only when its direction bit is set
    for (genvar g = 0; g < 32; g++) begin : g_pad
        assign pads[g] = dir_r[g] ? out_r[g] : 1'bz;
    end

endmodule

// File: rtl/ecore_lsu.sv
// ecore load/store unit: one request at a time to a byte-lane-less word RAM
// (sub-word stores are read-modify-write) or to the GPIO bank.
module ecore_lsu
    import ecore_pkg::*;
#(
    parameter int RAM_WORDS_LOG = 10,
    parameter int IO_BASE_BIT   = 31
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req,
    input  logic                     i_we,
    input  logic [1:0]               i_size,
    input  logic                     i_unsigned,
    input  logic [31:0]              i_addr,
    input  logic [31:0]              i_wdata,
    output logic                     o_ready,
    output logic                     o_done,
    output logic                     o_fault,
    output logic [31:0]              o_rdata,
    output logic [RAM_WORDS_LOG-1:0] o_ram_addr,
    output logic                     o_ram_we,
    output logic [31:0]              o_ram_wdata,
    input  logic [31:0]              i_ram_rdata,
    inout  wire  [31:0]              io_gpio_bank
);

    lsu_state_t               state_r, state_nx;
    logic                     we_r, uns_r, io_r, fault_r, done_r, ram_we_r;
    logic [1:0]               size_r;
    logic [3:0]               offs_r;
    logic [31:0]              wdata_r, rdata_r, ram_wdata_r;
    logic [RAM_WORDS_LOG-1:0] ram_addr_r;
    logic                     is_io_s, size_fault_s, fault_s, gpio_we_s, unused_s;
    logic [31:0]              gpio_rd_s;

    // Only the region bit, RAM index and low bits matter; the rest aliases
    assign unused_s = ^i_addr;
    assign is_io_s  = i_addr[IO_BASE_BIT];

    // Request legality: size/alignment, and IO is word-only
    always_comb begin
        size_fault_s = 1'b0;
        case (i_size)
            SZ_BYTE: size_fault_s = 1'b0;
            SZ_HALF: size_fault_s = i_addr[0];
            SZ_WORD: size_fault_s = (i_addr[1:0] != 2'b00);
            default: size_fault_s = 1'b1;
        endcase
        fault_s = size_fault_s | (is_io_s & (i_size != SZ_WORD));
    end

    // Next-state selection
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!i_req) begin
                    state_nx = ST_IDLE;
                end else if (fault_s || is_io_s) begin
                    state_nx = ST_RESP;
                end else if (i_we && (i_size == SZ_WORD)) begin
                    state_nx = ST_WRITE;
                end else begin
                    state_nx = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: state_nx = ST_RD_DATA;
            ST_RD_DATA:  state_nx = we_r ? ST_WRITE : ST_RESP;
            ST_WRITE:    state_nx = ST_RESP;
            ST_RESP:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Request capture, RAM port drive and response registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_r        <= 1'b0;
            size_r      <= SZ_BYTE;
            uns_r       <= 1'b0;
            offs_r      <= 4'h0;
            wdata_r     <= 32'h0000_0000;
            io_r        <= 1'b0;
            fault_r     <= 1'b0;
            done_r      <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            ram_addr_r  <= '0;
            ram_we_r    <= 1'b0;
            ram_wdata_r <= 32'h0000_0000;
        end else begin
            done_r   <= 1'b0;
            ram_we_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_req) begin
                        we_r    <= i_we;
                        size_r  <= i_size;
                        uns_r   <= i_unsigned;
                        offs_r  <= i_addr[3:0];
                        wdata_r <= i_wdata;
                        io_r    <= is_io_s;
                        fault_r <= fault_s;
                        // IO reads sample the register before any pending write lands
                        rdata_r <= (is_io_s && !fault_s && !i_we) ? gpio_rd_s : 32'h0000_0000;
                        if (fault_s || is_io_s) begin
                            done_r <= 1'b1;
                        end else begin
                            ram_addr_r <= i_addr[2 +: RAM_WORDS_LOG];
                            if (i_we && (i_size == SZ_WORD)) begin
                                ram_we_r    <= 1'b1;
                                ram_wdata_r <= i_wdata;
                            end else begin
                                ram_wdata_r <= ram_wdata_r;
                            end
                        end
                    end else begin
                        fault_r <= 1'b0;
                    end
                end
                ST_RD_DATA: begin
                    if (we_r) begin
                        ram_wdata_r <= store_merge(i_ram_rdata, wdata_r, size_r, offs_r[1:0]);
                        ram_we_r    <= 1'b1;
                    end else begin
                        rdata_r <= load_extract(i_ram_rdata, size_r, offs_r[1:0], uns_r);
                        done_r  <= 1'b1;
                    end
                end
                ST_WRITE: done_r  <= 1'b1;
                ST_RESP:  fault_r <= 1'b0;
                default:  done_r  <= 1'b0;
            endcase
        end
    end

    // IO stores commit at the edge that ends the response cycle
    assign gpio_we_s = (state_r == ST_RESP) && io_r && we_r && !fault_r;

    ecore_gpio_bank u_gpio (
        .clk       (i_clk),
        .rst       (i_rst),
        .wr_en     (gpio_we_s),
        .wr_offset (offs_r),
        .wr_data   (wdata_r),
        .rd_offset (i_addr[3:0]),
        .rd_data   (gpio_rd_s),
        .pads      (io_gpio_bank)
    );

    assign o_ready     = (state_r == ST_IDLE);
    assign o_done      = done_r;
    assign o_fault     = fault_r;
    assign o_rdata     = rdata_r;
    assign o_ram_addr  = ram_addr_r;
    // Reset kills a write already presented to the RAM in the same cycle
    assign o_ram_we    = ram_we_r & ~i_rst;
    assign o_ram_wdata = ram_wdata_r;

endmodule

// File: tb/tb_ecore_lsu.sv
// Directed self-checking bench for ecore_lsu with a behavioural word RAM.
module tb_ecore_lsu;

    logic        clk = 1'b0;
    logic        rst, req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready, done, fault, ram_we;
    logic [31:0] rdata, ram_wdata, ram_rdata;
    logic [9:0]  ram_addr;
    wire  [31:0] pads;
    logic        drv_en;
    logic [15:0] drv_val;

    logic [31:0] mem [0:1023];
    int          we_cnt = 0;
    int          n_checks = 0;
    int          n_fails = 0;

    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          we_before;

    always #5 clk = ~clk;

    assign pads[31:16] = drv_en ? drv_val : 16'hzzzz;

    // Synchronous single-port RAM: read data one cycle after the address
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            we_cnt        <= we_cnt + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    ecore_lsu #(.RAM_WORDS_LOG(10), .IO_BASE_BIT(31)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_we         (we),
        .i_size       (size),
        .i_unsigned   (uns),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_ready      (ready),
        .o_done       (done),
        .o_fault      (fault),
        .o_rdata      (rdata),
        .o_ram_addr   (ram_addr),
        .o_ram_we     (ram_we),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata),
        .io_gpio_bank (pads)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request from IDLE; returns result, fault and done latency, leaves LSU idle
    task automatic lsu_op(input logic i_we, input logic [1:0] i_size, input logic i_uns,
                          input logic [31:0] i_addr, input logic [31:0] i_wdata,
                          output logic [31:0] o_rd, output logic o_flt, output int o_lat);
        check("ready_before_req", ready, 32'd1);
        req = 1'b1; we = i_we; size = i_size; uns = i_uns; addr = i_addr; wdata = i_wdata;
        @(posedge clk); #1;
        req = 1'b0;
        o_lat = 1;
        while (!done && o_lat < 20) begin
            @(posedge clk); #1;
            o_lat++;
        end
        o_rd  = rdata;
        o_flt = fault;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; uns = 1'b0; size = 2'b00;
        addr = 32'h0; wdata = 32'h0; drv_en = 1'b0; drv_val = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 32'd1);
        check("rst_done", done, 32'd0);
        check("rst_fault", fault, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ram_we", ram_we, 32'd0);
        check("rst_ram_addr", {22'h0, ram_addr}, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store then sub-word loads
        lsu_op(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678, rd, flt, lat);
        check("sw_lat", lat, 32'd2);
        check("sw_fault", flt, 32'd0);
        check("sw_mem", mem[4], 32'h1234_5678);
        lsu_op(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, rd, flt, lat);
        check("lbu_lat", lat, 32'd3);
        check("lbu_data", rd, 32'h0000_0012);
        lsu_op(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, rd, flt, lat);
        check("lh_hi_data", rd, 32'h0000_1234);
        lsu_op(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0000_F000, rd, flt, lat);
        lsu_op(1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0, rd, flt, lat);
        check("lb_sext", rd, 32'hFFFF_FFF0);
        lsu_op(1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0, rd, flt, lat);
        check("lh_sext", rd, 32'hFFFF_F000);
        lsu_op(1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0, rd, flt, lat);
        check("lhu_zext", rd, 32'h0000_F000);

        // Byte store read-modify-write
        we_before = we_cnt;
        lsu_op(1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'h0000_00AB, rd, flt, lat);
        check("sb_lat", lat, 32'd4);
        check("sb_we_pulses", we_cnt - we_before, 32'd1);
        check("sb_mem", mem[4], 32'h12AB_5678);

        // Misaligned half: fault, no side effects
        we_before = we_cnt;
        lsu_op(1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_FFFF, rd, flt, lat);
        check("mis_lat", lat, 32'd1);
        check("mis_fault", flt, 32'd1);
        check("mis_rdata", rd, 32'h0);
        check("mis_no_we", we_cnt - we_before, 32'd0);
        check("mis_mem", mem[4], 32'h12AB_5678);
        lsu_op(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, rd, flt, lat);
        check("rsvd_fault", flt, 32'd1);
        lsu_op(1'b0, 2'b01, 1'b0, 32'h8000_0000, 32'h0, rd, flt, lat);
        check("io_half_fault", flt, 32'd1);

        // GPIO
        lsu_op(1'b1, 2'b10, 1'b0, 32'h8000_0004, 32'h0000_FFFF, rd, flt, lat);
        check("io_wr_lat", lat, 32'd1);
        check("io_wr_fault", flt, 32'd0);
        lsu_op(1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'hA5A5_A5A5, rd, flt, lat);
        check("pads_low", {16'h0, pads[15:0]}, 32'h0000_A5A5);
        lsu_op(1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h0, rd, flt, lat);
        check("io_rd_dir", rd, 32'h0000_FFFF);
        lsu_op(1'b0, 2'b10, 1'b0, 32'h8000_000C, 32'h0, rd, flt, lat);
        check("io_rd_unmapped", rd, 32'h0);
        check("io_unmapped_fault", flt, 32'd0);
        drv_en = 1'b1; drv_val = 16'h5A5A;
        repeat (2) @(posedge clk);
        #1;
        lsu_op(1'b0, 2'b10, 1'b0, 32'h8000_0008, 32'h0, rd, flt, lat);
        check("io_rd_in", rd, 32'h5A5A_A5A5);
        lsu_op(1'b1, 2'b10, 1'b0, 32'h8000_0008, 32'h0000_0000, rd, flt, lat);
        lsu_op(1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0, rd, flt, lat);
        check("io_rd_out", rd, 32'hA5A5_A5A5);
        drv_en = 1'b0;

        // Reset during the write cycle of a word store
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h0000_0010; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req = 1'b0;
        check("pre_rst_we", ram_we, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_we_gated", ram_we, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_ready", ready, 32'd1);
        check("post_rst_done", done, 32'd0);
        check("post_rst_mem", mem[4], 32'h12AB_5678);
        @(posedge clk); #1;
        check("post_rst_done2", done, 32'd0);
        lsu_op(1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h0, rd, flt, lat);
        check("post_rst_dir", rd, 32'h0);
        lsu_op(1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0, rd, flt, lat);
        check("post_rst_out", rd, 32'h0);

        // Held request: second load taken on the first IDLE cycle after done
        lsu_op(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'hCAFE_F00D, rd, flt, lat);
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h0000_0000;
        @(posedge clk); #1;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("held1_lat", lat, 32'd3);
        check("held1_data", rdata, 32'hCAFE_F00D);
        check("held_resp_ready", ready, 32'd0);
        addr = 32'h0000_1000;
        @(posedge clk); #1;
        check("held_idle_ready", ready, 32'd1);
        check("held_idle_done", done, 32'd0);
        @(posedge clk); #1;
        check("held2_accepted", ready, 32'd0);
        req = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("held2_lat", lat, 32'd3);
        check("held2_alias_data", rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
